// File: rtl/key_schedule_gen_if.sv
// Round-key stream bundle: start/abort/key load towards the schedule generator,
// round key, index and status back towards the consumer.
interface key_schedule_gen_if #(
    parameter int KEY_W = 20,
    parameter int RK_W  = 16,
    parameter int CNT_W = 5
);
    logic             start;
    logic             abort;
    logic [KEY_W-1:0] key_in;
    logic [RK_W-1:0]  rk;
    logic             rk_valid;
    logic             rk_ready;
    logic [CNT_W:0]   rk_index;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, key_in, rk_ready,
        input  rk, rk_valid, rk_index, busy, done
    );

    modport slave (
        input  start, abort, key_in, rk_ready,
        output rk, rk_valid, rk_index, busy, done
    );
endinterface

// File: rtl/key_schedule_gen.sv
// Sequential PRESENT-style key schedule: loads a master key and streams NUM_ROUNDS+1
// round keys over a valid/ready handshake, one key register update per accepted beat.
module key_schedule_gen #(
    parameter int KEY_W      = 20,
    parameter int RK_W       = 16,
    parameter int ROT        = 13,
    parameter int NUM_SBOX   = 1,
    parameter int NUM_ROUNDS = 31,
    parameter int CNT_W      = 5,
    parameter int CNT_POS    = 4,
    parameter int CNT_MODE   = 0
) (
    input logic clk,
    input logic rst,
    key_schedule_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W:0] LAST_IDX  = (CNT_W+1)'(NUM_ROUNDS + 1);
    localparam logic [CNT_W:0] FIRST_IDX = (CNT_W+1)'(1);

    state_t           state_reg, state_next;
    logic [KEY_W-1:0] key_reg, key_next;
    logic [CNT_W:0]   cnt_reg, cnt_next;

    logic [KEY_W-1:0]      rot_key;
    logic [4*NUM_SBOX-1:0] sbox_out;
    logic [KEY_W-1:0]      sub_key;
    logic [KEY_W-1:0]      inj_mask;
    logic [KEY_W-1:0]      upd_key;

    logic rk_valid_int;
    logic busy_int;
    logic done_int;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Key update datapath: rotate left, substitute the top nibbles, inject the round counter.
    assign rot_key = {key_reg[KEY_W-ROT-1:0], key_reg[KEY_W-1:KEY_W-ROT]};

    generate
        for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_sbox
            assign sbox_out[4*gi +: 4] = sbox4(rot_key[KEY_W-4*NUM_SBOX+4*gi +: 4]);
        end
    endgenerate

    always_comb begin
        sub_key = rot_key;
        sub_key[KEY_W-1 -: 4*NUM_SBOX] = sbox_out;
    end

    generate
        if (CNT_MODE == 0) begin : g_inj_rep
            // Only the counter lsb matters: it is spread over a 4-bit field.
            assign inj_mask = KEY_W'({4{cnt_reg[0]}}) << CNT_POS;
        end else begin : g_inj_xor
            assign inj_mask = KEY_W'(cnt_reg[CNT_W-1:0]) << CNT_POS;
        end
    endgenerate

    assign upd_key = sub_key ^ inj_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        key_next     = key_reg;
        cnt_next     = cnt_reg;
        rk_valid_int = 1'b0;
        busy_int     = 1'b0;
        done_int     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    key_next   = bus.key_in;
                    cnt_next   = FIRST_IDX;
                    state_next = RUN;
                end
            end
            RUN: begin
                rk_valid_int = 1'b1;
                busy_int     = 1'b1;
                // An abort still consumes a coincident beat but produces no further key.
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.rk_ready) begin
                    if (cnt_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        key_next = upd_key;
                        cnt_next = cnt_reg + FIRST_IDX;
                    end
                end
            end
            DONE: begin
                done_int   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rk       = key_reg[KEY_W-1 -: RK_W];
    assign bus.rk_index = cnt_reg;
    assign bus.rk_valid = rk_valid_int;
    assign bus.busy     = busy_int;
    assign bus.done     = done_int;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Bench for key_schedule_gen: a 20-bit default instance and a PRESENT-80 instance,
// with expected round keys queued at start and popped on every accepted beat.
module tb_key_schedule_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_schedule_gen_if #(.KEY_W(20), .RK_W(16), .CNT_W(5)) a_if ();
    key_schedule_gen_if #(.KEY_W(80), .RK_W(64), .CNT_W(5)) p_if ();

    key_schedule_gen #(
        .KEY_W(20), .RK_W(16), .ROT(13), .NUM_SBOX(1), .NUM_ROUNDS(31),
        .CNT_W(5), .CNT_POS(4), .CNT_MODE(0)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(a_if)
    );

    key_schedule_gen #(
        .KEY_W(80), .RK_W(64), .ROT(61), .NUM_SBOX(1), .NUM_ROUNDS(31),
        .CNT_W(5), .CNT_POS(15), .CNT_MODE(1)
    ) dut_p (
        .clk(clk),
        .rst(rst),
        .bus(p_if)
    );

    typedef struct packed {
        logic [63:0] rk;
        logic [5:0]  idx;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sbox_m(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[4*x +: 4];
    endfunction

    // Reference update for the 20-bit instance: rotl 13, S-box on [19:16], c[0] spread over [7:4].
    function automatic logic [19:0] f20(input logic [19:0] k, input int c);
        logic [19:0] r;
        r = {k[6:0], k[19:7]};
        r[19:16] = sbox_m(r[19:16]);
        r[7:4] = r[7:4] ^ {4{c[0]}};
        return r;
    endfunction

    // PRESENT-80 key update: rotl 61, S-box on [79:76], round counter into [19:15].
    function automatic logic [79:0] f80(input logic [79:0] k, input int c);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox_m(r[79:76]);
        r[19:15] = r[19:15] ^ c[4:0];
        return r;
    endfunction

    task automatic run_a(input logic [19:0] key, input int stall_idx, input int abort_idx,
                         input int rst_idx, input bit hold_start);
        exp_t        e;
        logic [19:0] k;
        int          stalls = 0;
        int          beats  = 0;
        int          cyc    = 0;
        k = key;
        for (int r = 1; r <= 32; r++) begin
            e.rk  = 64'(k[19:4]);
            e.idx = 6'(r);
            sb_q.push_back(e);
            k = f20(k, r);
        end
        a_if.key_in = key;
        a_if.start  = 1'b1;
        step();
        a_if.start = hold_start;
        while (sb_q.size() > 0 && cyc < 300) begin
            cyc++;
            e = sb_q[0];
            chk("rk_valid", 80'(a_if.rk_valid), 80'(1));
            chk("busy", 80'(a_if.busy), 80'(1));
            chk("rk", 80'(a_if.rk), e.rk);
            chk("rk_index", 80'(a_if.rk_index), 80'(e.idx));
            if (key == 20'h0 && a_if.rk_index == 6'd2)
                chk("rk2_ref", 80'(a_if.rk), 80'h0C00F);
            if (rst_idx == int'(a_if.rk_index)) begin
                rst = 1'b1;
                a_if.rk_ready = 1'b0;
                step();
                rst = 1'b0;
                chk("rst_rk", 80'(a_if.rk), 80'(0));
                chk("rst_idx", 80'(a_if.rk_index), 80'(0));
                chk("rst_valid", 80'(a_if.rk_valid), 80'(0));
                chk("rst_busy", 80'(a_if.busy), 80'(0));
                chk("rst_done", 80'(a_if.done), 80'(0));
                sb_q.delete();
                return;
            end
            if (abort_idx == int'(a_if.rk_index)) begin
                a_if.abort    = 1'b1;
                a_if.rk_ready = 1'b1;
                step();
                a_if.abort    = 1'b0;
                a_if.rk_ready = 1'b0;
                chk("abort_valid", 80'(a_if.rk_valid), 80'(0));
                chk("abort_busy", 80'(a_if.busy), 80'(0));
                chk("abort_done", 80'(a_if.done), 80'(0));
                step();
                chk("abort_done2", 80'(a_if.done), 80'(0));
                chk("abort_valid2", 80'(a_if.rk_valid), 80'(0));
                sb_q.delete();
                return;
            end
            if (int'(a_if.rk_index) == stall_idx && stalls < 3) begin
                a_if.rk_ready = 1'b0;
                stalls++;
            end else begin
                a_if.rk_ready = 1'b1;
                void'(sb_q.pop_front());
                beats++;
                if (sb_q.size() == 0) a_if.start = 1'b0;
            end
            step();
        end
        a_if.rk_ready = 1'b0;
        chk("drain", 80'(sb_q.size()), 80'(0));
        chk("beats", 80'(beats), 80'(32));
        chk("done_pulse", 80'(a_if.done), 80'(1));
        chk("done_valid", 80'(a_if.rk_valid), 80'(0));
        chk("done_busy", 80'(a_if.busy), 80'(0));
        step();
        chk("done_clear", 80'(a_if.done), 80'(0));
        chk("idle_busy", 80'(a_if.busy), 80'(0));
        chk("idle_valid", 80'(a_if.rk_valid), 80'(0));
    endtask

    task automatic run_p();
        exp_t        e;
        logic [79:0] k;
        logic [63:0] ref_v [3];
        int          beats = 0;
        int          cyc   = 0;
        ref_v[0] = 64'h0000000000000000;
        ref_v[1] = 64'hC000000000000000;
        ref_v[2] = 64'h5000180000000001;
        k = '0;
        for (int r = 1; r <= 32; r++) begin
            e.rk  = k[79:16];
            e.idx = 6'(r);
            sb_q.push_back(e);
            k = f80(k, r);
        end
        p_if.key_in = '0;
        p_if.start  = 1'b1;
        step();
        p_if.start    = 1'b0;
        p_if.rk_ready = 1'b1;
        while (sb_q.size() > 0 && cyc < 300) begin
            cyc++;
            e = sb_q.pop_front();
            chk("p80_valid", 80'(p_if.rk_valid), 80'(1));
            chk("p80_rk", 80'(p_if.rk), 80'(e.rk));
            chk("p80_idx", 80'(p_if.rk_index), 80'(e.idx));
            if (beats < 3) chk("p80_ref", 80'(p_if.rk), 80'(ref_v[beats]));
            beats++;
            step();
        end
        p_if.rk_ready = 1'b0;
        chk("p80_beats", 80'(beats), 80'(32));
        chk("p80_done", 80'(p_if.done), 80'(1));
        step();
        chk("p80_done_clear", 80'(p_if.done), 80'(0));
    endtask

    initial begin
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.key_in = '0; a_if.rk_ready = 1'b0;
        p_if.start = 1'b0; p_if.abort = 1'b0; p_if.key_in = '0; p_if.rk_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_rk", 80'(a_if.rk), 80'(0));
        chk("reset_idx", 80'(a_if.rk_index), 80'(0));
        chk("reset_valid", 80'(a_if.rk_valid), 80'(0));
        chk("reset_busy", 80'(a_if.busy), 80'(0));
        chk("reset_done", 80'(a_if.done), 80'(0));

        run_a(20'h00000, -1, -1, -1, 1'b0);
        $display("test1 key=0 full schedule checks=%0d failures=%0d", checks, failures);
        run_a(20'h3A5C1, 5, -1, -1, 1'b0);
        $display("test2 stall at idx5 checks=%0d failures=%0d", checks, failures);
        run_a(20'h12345, -1, 10, -1, 1'b0);
        run_a(20'h12345, -1, -1, -1, 1'b0);
        $display("test3 abort at idx10 and restart checks=%0d failures=%0d", checks, failures);
        run_a(20'h00000, -1, -1, -1, 1'b1);
        $display("test4 start held in RUN checks=%0d failures=%0d", checks, failures);
        run_p();
        $display("test5 PRESENT-80 key=0 checks=%0d failures=%0d", checks, failures);
        run_a(20'h0F0F0, -1, -1, 7, 1'b0);
        run_a(20'hFFFFF, -1, -1, -1, 1'b0);
        $display("test6 rst at idx7 then key=FFFFF checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
